// File: rtl/i2s_tx_fifo.sv
// ---------------------------------------------------------------------------
// i2s_tx_fifo
// Stereo I2S / left-justified serial transmitter fed by a small frame FIFO.
// BCLK and LRCLK are produced as registered outputs in the clk domain, paced
// by an internal divider, so no derived clocks exist anywhere in the block.
//
// Ports
//   clk, rst_n              system clock, asynchronous active-low reset
//   enable                  1 = run the serial link, 0 = hold it idle
//   fmt                     0 = I2S (Philips), 1 = left-justified; latched per frame
//   in_left, in_right       parallel samples (two's complement)
//   in_valid / in_ready     frame handshake into the FIFO (ready = not full)
//   clear_underrun          pulse that clears the sticky underrun flag
//   underrun                set when a frame starts with the FIFO empty
//   fifo_level              number of frames currently stored
//   i2s_bclk/lrclk/data     serial outputs, all registered
// ---------------------------------------------------------------------------
module i2s_tx_fifo #(
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_DIV   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          fmt,
    input  logic [SAMPLE_W-1:0]           in_left,
    input  logic [SAMPLE_W-1:0]           in_right,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          clear_underrun,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_data
);

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int PW        = $clog2(2 * SLOT_W);
    localparam int DW        = $clog2(2 * BCLK_DIV);
    localparam int P_LAST_I  = 2 * SLOT_W - 1;
    localparam int D_LAST_I  = 2 * BCLK_DIV - 1;
    localparam int D_PRE_I   = BCLK_DIV - 1;
    localparam int LVL_FULL_I = FIFO_DEPTH;

    localparam logic [PW-1:0] P_LAST   = P_LAST_I[PW-1:0];
    localparam logic [DW-1:0] D_LAST   = D_LAST_I[DW-1:0];
    localparam logic [DW-1:0] D_PRE    = D_PRE_I[DW-1:0];
    localparam logic [AW:0]   LVL_FULL = LVL_FULL_I[AW:0];

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    logic [DW-1:0]            div_cnt;
    logic [PW-1:0]            pos;
    logic [SAMPLE_W-1:0]      cur_left;
    logic [SAMPLE_W-1:0]      cur_right;
    logic                     cur_fmt;

    logic [2*SAMPLE_W-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;

    logic                     shift_evt;
    logic                     frame_start;
    logic [PW-1:0]            pos_next;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic [SAMPLE_W-1:0]      nx_left;
    logic [SAMPLE_W-1:0]      nx_right;
    logic                     nx_fmt;

    // Returns {lrclk, data} for bit position p of a frame. The slot word is
    // MSB first; I2S delays the MSB by one BCLK, left-justified does not, and
    // the LRCLK polarity flips between the two formats.
    function automatic logic [1:0] slot_out(input logic [PW-1:0] p,
                                            input logic [SAMPLE_W-1:0] l,
                                            input logic [SAMPLE_W-1:0] r,
                                            input logic lj);
        int                  k;
        logic                right_slot;
        logic [SAMPLE_W-1:0] s;
        logic [SAMPLE_W-1:0] sh;
        logic                d;
        right_slot = (int'(p) >= SLOT_W);
        k          = right_slot ? int'(p) - SLOT_W : int'(p);
        s          = right_slot ? r : l;
        d          = 1'b0;
        sh         = '0;
        if (lj) begin
            if (k < SAMPLE_W) begin
                sh = s >> (SAMPLE_W - 1 - k);
                d  = sh[0];
            end
        end else if (k >= 1 && k <= SAMPLE_W) begin
            sh = s >> (SAMPLE_W - k);
            d  = sh[0];
        end
        return {right_slot ^ lj, d};
    endfunction

    assign fifo_empty = (fifo_level == '0);
    assign in_ready   = (fifo_level != LVL_FULL);
    assign push       = in_valid && in_ready;

    // A shift event is the first RUN cycle or the end of a BCLK period; it
    // also decides the next bit position, whose zero marks a frame start.
    always_comb begin
        shift_evt = 1'b0;
        pos_next  = '0;
        if (enable) begin
            if (state == IDLE) begin
                shift_evt = 1'b1;
            end else if (div_cnt == D_LAST) begin
                shift_evt = 1'b1;
                pos_next  = (pos == P_LAST) ? '0 : pos + 1'b1;
            end
        end
    end

    assign frame_start = shift_evt && (pos_next == '0);
    assign pop         = frame_start && !fifo_empty;

    // Frame to serialize from the next shift onwards: the FIFO head (or
    // silence on underrun) at a frame start, otherwise the frame in flight.
    always_comb begin
        nx_left  = cur_left;
        nx_right = cur_right;
        nx_fmt   = cur_fmt;
        if (frame_start) begin
            nx_fmt = fmt;
            if (!fifo_empty) begin
                {nx_left, nx_right} = mem[rd_ptr];
            end else begin
                nx_left  = '0;
                nx_right = '0;
            end
        end
    end

    // Frame storage; contents need no reset because the pointers and level
    // define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_left, in_right};
        end
    end

    // FIFO bookkeeping and the sticky underrun flag. A simultaneous push and
    // pop leaves the level alone, and setting the flag beats clearing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            underrun   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
            if (frame_start && fifo_empty) begin
                underrun <= 1'b1;
            end else if (clear_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

    // Link state machine. BCLK rises halfway through each period and falls
    // together with the shift, so LRCLK/data are stable for BCLK_DIV cycles
    // before every rising edge. Dropping enable abandons the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            pos       <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_data  <= 1'b0;
            cur_left  <= '0;
            cur_right <= '0;
            cur_fmt   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt  <= '0;
                    pos      <= '0;
                    i2s_bclk <= 1'b0;
                    if (enable) begin
                        state                  <= RUN;
                        {i2s_lrclk, i2s_data}  <= slot_out('0, nx_left, nx_right, nx_fmt);
                        cur_left               <= nx_left;
                        cur_right              <= nx_right;
                        cur_fmt                <= nx_fmt;
                    end else begin
                        i2s_lrclk <= 1'b0;
                        i2s_data  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state     <= IDLE;
                        div_cnt   <= '0;
                        pos       <= '0;
                        i2s_bclk  <= 1'b0;
                        i2s_lrclk <= 1'b0;
                        i2s_data  <= 1'b0;
                    end else if (shift_evt) begin
                        div_cnt                <= '0;
                        pos                    <= pos_next;
                        i2s_bclk               <= 1'b0;
                        {i2s_lrclk, i2s_data}  <= slot_out(pos_next, nx_left, nx_right, nx_fmt);
                        cur_left               <= nx_left;
                        cur_right              <= nx_right;
                        cur_fmt                <= nx_fmt;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        if (div_cnt == D_PRE) begin
                            i2s_bclk <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
